// File: rtl/modulator_pkg.sv
// Shared types and default constants for the modulator front-end (Pack stage).
package modulator_pkg;

   // Frame sequencer FSM states.
   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SYNC,
      LEN,
      PAY,
      DRAIN,
      GAP
   } state_t;

   localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'h55;
   localparam logic [15:0] DEF_SYNC_WORD     = 16'hD391;
   localparam int          DEF_GAP_LEN       = 16;

   // Header bytes that follow the preamble: two sync bytes plus the length byte.
   localparam int HDR_LEN = 3;

   // Total bytes on the wire for one frame carrying n payload bytes.
   function automatic int frame_bytes(input int preamble_len, input int n);
      return preamble_len + HDR_LEN + n;
   endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake and control bundle between a host/modulator pair and the frame sequencer.
// The master side drives start/length, payload and downstream ready; the
// slave side (the sequencer) drives the payload ready, output byte and status.
interface frame_sequencer_if #(
   parameter int SIZE_INPUT_BIT = 8
);
   logic                      i_start;
   logic [7:0]                i_length;
   logic [SIZE_INPUT_BIT-1:0] i_data;
   logic                      i_valid;
   logic                      o_ready_payload;
   logic [SIZE_INPUT_BIT-1:0] o_data;
   logic                      o_valid;
   logic                      i_ready_output;
   logic                      o_busy;
   logic                      o_done;

   modport master (
      output i_start, i_length, i_data, i_valid, i_ready_output,
      input  o_ready_payload, o_data, o_valid, o_busy, o_done
   );

   modport slave (
      input  i_start, i_length, i_data, i_valid, i_ready_output,
      output o_ready_payload, o_data, o_valid, o_busy, o_done
   );
endinterface

// File: rtl/frame_sequencer.sv
// Frame builder in front of the modulator byte input: preamble, sync word,
// length byte, then N host payload bytes, followed by an enforced idle gap.
// Output is a single valid/ready register that can reload on the cycle it
// transfers, so an unstalled frame streams at one byte per cycle.
module frame_sequencer
   import modulator_pkg::*;
#(
   parameter int          SIZE_INPUT_BIT = 8,
   parameter int          PREAMBLE_LEN   = 4,
   parameter logic [7:0]  PREAMBLE_BYTE  = DEF_PREAMBLE_BYTE,
   parameter logic [15:0] SYNC_WORD      = DEF_SYNC_WORD,
   parameter int          GAP_LEN        = DEF_GAP_LEN
) (
   input logic               i_clk,
   input logic               i_reset,
   frame_sequencer_if.slave  bus
);

   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
   localparam logic [7:0] GAP_INIT = 8'(GAP_LEN);

   state_t                    state_reg;
   logic [3:0]                cnt_reg;        // preamble / sync byte index
   logic [7:0]                len_reg;        // latched payload length N
   logic [7:0]                remaining_reg;  // payload bytes still to load
   logic [7:0]                gap_reg;        // idle cycles left after the frame
   logic [SIZE_INPUT_BIT-1:0] data_reg;
   logic                      valid_reg;
   logic                      busy_reg;

   logic load;
   logic xfer;

   // The output register may take a new byte when empty or when draining this cycle.
   assign load = !valid_reg || bus.i_ready_output;
   assign xfer = valid_reg && bus.i_ready_output;

   // Payload is pulled only in PAY, and only when the output register can take it.
   assign bus.o_ready_payload = (state_reg == PAY) && load;
   // Done marks the transfer of the final frame byte itself.
   assign bus.o_done          = (state_reg == DRAIN) && xfer;
   assign bus.o_data          = data_reg;
   assign bus.o_valid         = valid_reg;
   assign bus.o_busy          = busy_reg;

   // Frame FSM with its counters and the output byte register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         len_reg       <= '0;
         remaining_reg <= '0;
         gap_reg       <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         // A transfer empties the register unless a state below reloads it.
         if (xfer) begin
            valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               busy_reg <= 1'b0;
               if (bus.i_start) begin
                  len_reg   <= bus.i_length;
                  busy_reg  <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= PRE;
               end
            end

            PRE: begin
               if (load) begin
                  data_reg  <= SIZE_INPUT_BIT'(PREAMBLE_BYTE);
                  valid_reg <= 1'b1;
                  if (cnt_reg == PRE_LAST) begin
                     cnt_reg   <= '0;
                     state_reg <= SYNC;
                  end else begin
                     cnt_reg <= cnt_reg + 4'd1;
                  end
               end
            end

            SYNC: begin
               if (load) begin
                  valid_reg <= 1'b1;
                  if (cnt_reg == 4'd0) begin
                     data_reg <= SIZE_INPUT_BIT'(SYNC_WORD[15:8]);
                     cnt_reg  <= 4'd1;
                  end else begin
                     data_reg  <= SIZE_INPUT_BIT'(SYNC_WORD[7:0]);
                     cnt_reg   <= '0;
                     state_reg <= LEN;
                  end
               end
            end

            LEN: begin
               if (load) begin
                  data_reg  <= SIZE_INPUT_BIT'(len_reg);
                  valid_reg <= 1'b1;
                  if (len_reg == 8'd0) begin
                     state_reg <= DRAIN;
                  end else begin
                     remaining_reg <= len_reg;
                     state_reg     <= PAY;
                  end
               end
            end

            PAY: begin
               // No byte is invented while the host is starved.
               if (bus.i_valid && load) begin
                  data_reg      <= bus.i_data;
                  valid_reg     <= 1'b1;
                  remaining_reg <= remaining_reg - 8'd1;
                  if (remaining_reg == 8'd1) begin
                     state_reg <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (xfer) begin
                  if (GAP_LEN == 0) begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     gap_reg   <= GAP_INIT;
                     state_reg <= GAP;
                  end
               end
            end

            GAP: begin
               gap_reg <= gap_reg - 8'd1;
               if (gap_reg <= 8'd1) begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus pushes expected bytes,
// a negedge monitor pops and compares every downstream transfer.
module tb_frame_sequencer;
   import modulator_pkg::*;

   localparam int GAP = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_reset;

   frame_sequencer_if #(.SIZE_INPUT_BIT(8)) bus ();

   frame_sequencer #(
      .SIZE_INPUT_BIT(8),
      .PREAMBLE_LEN  (4),
      .PREAMBLE_BYTE (8'h55),
      .SYNC_WORD     (16'hD391),
      .GAP_LEN       (GAP)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .bus    (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   exp_t       exp_q[$];
   logic [7:0] host_q[$];

   int   xfer_cnt     = 0;
   int   low_cnt      = 0;
   int   consumed_cnt = 0;
   int   starve_cnt   = 0;
   int   bp_idx       = 0;
   bit   in_frame     = 0;
   bit   rp_seen      = 0;
   bit   starve_arm   = 0;
   bit   bp_mode      = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Host payload source and downstream ready generator.
   initial begin
      bit host_take;
      bus.i_valid        = 1'b0;
      bus.i_data         = 8'h00;
      bus.i_ready_output = 1'b1;
      forever begin
         @(negedge i_clk);
         host_take = bus.i_valid && bus.o_ready_payload;
         @(posedge i_clk);
         #1;
         if (host_take && host_q.size() > 0) begin
            void'(host_q.pop_front());
            consumed_cnt++;
            if (starve_arm) begin
               starve_arm = 0;
               starve_cnt = 5;
            end
         end
         if (starve_cnt > 0) begin
            starve_cnt--;
            bus.i_valid = 1'b0;
         end else if (host_q.size() > 0) begin
            bus.i_valid = 1'b1;
            bus.i_data  = host_q[0];
         end else begin
            bus.i_valid = 1'b0;
         end
         if (bp_mode) begin
            case (bp_idx)
               0, 3:    bus.i_ready_output = 1'b1;
               1, 2:    bus.i_ready_output = 1'b0;
               default: bus.i_ready_output = 1'($urandom_range(0, 1));
            endcase
            bp_idx++;
         end else begin
            bus.i_ready_output = 1'b1;
         end
      end
   end

   // Monitor: compare each transfer against the scoreboard and check stall stability.
   initial begin
      bit         prev_stall = 0;
      logic [7:0] prev_data  = 8'h00;
      exp_t       e;
      forever begin
         @(negedge i_clk);
         if (!i_reset) begin
            prev_stall = 0;
         end else begin
            if (bus.o_ready_payload) rp_seen = 1;
            if (prev_stall) begin
               chk("hold_valid", int'(bus.o_valid), 1);
               chk("hold_data", int'(bus.o_data), int'(prev_data));
            end
            if (bus.o_valid && bus.i_ready_output) begin
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_xfer", int'(bus.o_data), -1);
               end else begin
                  e = exp_q.pop_front();
                  $display("xfer %0d: data=%02h done=%0b", xfer_cnt, bus.o_data, bus.o_done);
                  chk("data", int'(bus.o_data), int'(e.data));
                  chk("done_on_xfer", int'(bus.o_done), int'(e.last));
               end
            end else begin
               chk("stray_done", int'(bus.o_done), 0);
            end
            if (in_frame && !bus.o_valid) low_cnt++;
            if (bus.o_valid) in_frame = 1;
            if (bus.o_done)  in_frame = 0;
            prev_stall = bus.o_valid && !bus.i_ready_output;
            prev_data  = bus.o_data;
         end
      end
   end

   task automatic reset_stats();
      xfer_cnt = 0;
      low_cnt  = 0;
      in_frame = 0;
      rp_seen  = 0;
   endtask

   task automatic push_header(input int n);
      for (int i = 0; i < 4; i++) exp_q.push_back('{data: 8'h55, last: 1'b0});
      exp_q.push_back('{data: 8'hD3, last: 1'b0});
      exp_q.push_back('{data: 8'h91, last: 1'b0});
      exp_q.push_back('{data: 8'(n), last: (n == 0)});
   endtask

   task automatic push_pay(input logic [7:0] b, input bit last);
      host_q.push_back(b);
      exp_q.push_back('{data: b, last: last});
   endtask

   task automatic pulse_start(input int n);
      @(posedge i_clk);
      #1;
      bus.i_start  = 1'b1;
      bus.i_length = 8'(n);
      @(posedge i_clk);
      #1;
      bus.i_start  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (bus.o_done) begin
            seen = 1;
            break;
         end
      end
      chk("done_seen", int'(seen), 1);
   endtask

   // Count cycles that o_busy stays high after done; optionally pulse start inside the gap.
   task automatic measure_gap(input int pulse_at);
      int cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (!bus.o_busy) break;
         cnt++;
         if (cnt == pulse_at) begin
            bus.i_start  = 1'b1;
            bus.i_length = 8'd9;
         end else begin
            bus.i_start  = 1'b0;
         end
      end
      bus.i_start = 1'b0;
      chk("gap_cycles", cnt, GAP);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, int'(bus.o_valid), 0);
      chk({tag, "_data"},  int'(bus.o_data), 0);
      chk({tag, "_busy"},  int'(bus.o_busy), 0);
      chk({tag, "_done"},  int'(bus.o_done), 0);
      chk({tag, "_rdy"},   int'(bus.o_ready_payload), 0);
   endtask

   initial begin
      bit got;
      bus.i_start  = 1'b0;
      bus.i_length = 8'd0;
      i_reset      = 1'b0;
      repeat (3) @(negedge i_clk);
      check_outputs_zero("reset");
      i_reset = 1'b1;
      @(negedge i_clk);

      // Basic frame, N=2, no backpressure.
      reset_stats();
      push_header(2);
      push_pay(8'hA1, 1'b0);
      push_pay(8'hA2, 1'b1);
      pulse_start(2);
      @(negedge i_clk);
      chk("lat_pre", int'(bus.o_valid), 0);
      @(negedge i_clk);
      chk("lat_first", int'(bus.o_valid), 1);
      wait_done(200);
      measure_gap(0);
      chk("basic_bubbles", low_cnt, 0);
      chk("basic_len", xfer_cnt, frame_bytes(4, 2));
      chk("basic_rp_seen", int'(rp_seen), 1);
      chk("basic_q_empty", exp_q.size(), 0);

      // Zero-length frame.
      reset_stats();
      push_header(0);
      pulse_start(0);
      wait_done(200);
      measure_gap(0);
      chk("zero_rp_never", int'(rp_seen), 0);
      chk("zero_len", xfer_cnt, frame_bytes(4, 0));
      chk("zero_q_empty", exp_q.size(), 0);

      // Backpressure: ready pattern 1,0,0,1 then random.
      reset_stats();
      push_header(3);
      push_pay(8'hB1, 1'b0);
      push_pay(8'hB2, 1'b0);
      push_pay(8'hB3, 1'b1);
      bp_idx  = 0;
      bp_mode = 1;
      pulse_start(3);
      wait_done(2000);
      bp_mode = 0;
      measure_gap(0);
      chk("bp_len", xfer_cnt, frame_bytes(4, 3));
      chk("bp_q_empty", exp_q.size(), 0);

      // Host starvation with start pulsed mid-PAY and during GAP.
      reset_stats();
      consumed_cnt = 0;
      push_header(3);
      push_pay(8'hC1, 1'b0);
      push_pay(8'hC2, 1'b0);
      push_pay(8'hC3, 1'b1);
      host_q.push_back(8'hC4);
      starve_arm = 1;
      pulse_start(3);
      got = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (consumed_cnt >= 1) begin
            got = 1;
            break;
         end
      end
      chk("first_payload_taken", int'(got), 1);
      bus.i_start  = 1'b1;
      bus.i_length = 8'd9;
      @(negedge i_clk);
      bus.i_start  = 1'b0;
      wait_done(200);
      measure_gap(3);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("no_restart", int'(bus.o_valid), 0);
      end
      chk("starve_low_cycles", low_cnt, 5);
      chk("starve_consumed", consumed_cnt, 3);
      chk("starve_host_left", host_q.size(), 1);
      chk("starve_q_empty", exp_q.size(), 0);
      host_q.delete();
      @(negedge i_clk);

      // Asynchronous reset during SYNC, then a fresh frame.
      reset_stats();
      push_header(2);
      push_pay(8'h11, 1'b0);
      push_pay(8'h22, 1'b1);
      pulse_start(2);
      got = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (xfer_cnt >= 4) begin
            got = 1;
            break;
         end
      end
      chk("reached_sync", int'(got), 1);
      @(posedge i_clk);
      #2;
      i_reset = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      exp_q.delete();
      host_q.delete();
      repeat (2) @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);

      reset_stats();
      push_header(2);
      push_pay(8'hE1, 1'b0);
      push_pay(8'hE2, 1'b1);
      pulse_start(2);
      wait_done(200);
      measure_gap(0);
      chk("post_rst_len", xfer_cnt, frame_bytes(4, 2));
      chk("post_rst_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Byte-stream frame builder placed in front of the modulator's byte input (Pack stage).
- On a start command it emits preamble bytes, a 2-byte sync word and a length byte, then forwards exactly N payload bytes from the host stream.
- After the frame it enforces an idle gap before the next frame can start.
- All output transfers use a valid/ready handshake, with ready taken from the modulator's o_ready.

Parameters:
- SIZE_INPUT_BIT, 8, byte width of payload and output data.
- PREAMBLE_LEN, 4, number of preamble bytes (1..15).
- PREAMBLE_BYTE, 8'h55, value of every preamble byte.
- SYNC_WORD, 16'hD391, sync word, sent MSB byte first.
- GAP_LEN, 16, idle cycles after the last byte transfer before start is accepted (0..255).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle frame request; honoured only when o_busy=0.
- i_length  in  8  payload byte count N, 0..255; sampled when start is honoured.
- i_data  in  SIZE_INPUT_BIT  host payload byte.
- i_valid  in  1  host payload valid.
- o_ready_payload  out  1  sequencer accepts a payload byte this cycle.
- o_data  out  SIZE_INPUT_BIT  byte to the modulator.
- o_valid  out  1  o_data valid.
- i_ready_output  in  1  modulator ready (its o_ready).
- o_busy  out  1  high from an honoured start until the gap ends.
- o_done  out  1  one-cycle pulse when the last frame byte transfers downstream.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; o_data=0, o_valid=0, o_ready_payload=0, o_busy=0, o_done=0; all counters 0. Reset mid-frame aborts the frame with no further output. After release, the first honoured start is no earlier than the next rising edge.
- Output stage: a single register (o_data, o_valid).
  - Transfer occurs when o_valid && i_ready_output.
  - Once o_valid is high, o_data is held stable and o_valid stays high until that transfer.
  - The register may be reloaded in the same cycle it transfers, giving 1 byte/cycle throughput.
- Load condition: load = (!o_valid || i_ready_output).
- States and transitions:
  - IDLE: o_busy=0. If i_start, latch N=i_length, set o_busy=1, go to PRE with byte counter 0. Start is ignored in every other state.
  - PRE: on load, place PREAMBLE_BYTE in the output register and increment the counter. After PREAMBLE_LEN loads, go to SYNC.
  - SYNC: on load, place SYNC_WORD[15:8], then SYNC_WORD[7:0]. Then go to LEN.
  - LEN: on load, place the byte N. If N=0, go to DRAIN; otherwise load remaining=N and go to PAY.
  - PAY:
    - o_ready_payload = load (combinational from i_ready_output and o_valid).
    - When i_valid && o_ready_payload, place i_data in the output register and decrement remaining.
    - The load that sets remaining to 0 moves to DRAIN.
    - No output byte is invented when i_valid=0; o_valid drops after the pending transfer.
  - DRAIN: o_ready_payload=0. When the final byte transfers (o_valid && i_ready_output), pulse o_done for one cycle, set gap counter = GAP_LEN, go to GAP (or IDLE if GAP_LEN=0).
  - GAP: decrement each cycle; at 0 go to IDLE. o_busy stays 1 through GAP.
- o_ready_payload is 0 in every state except PAY, so extra host bytes are never consumed.
- Backpressure: i_ready_output=0 freezes the sequence; no byte is skipped or duplicated.
- Frame length in bytes: PREAMBLE_LEN + 3 + N.
- Minimum latency: start to first o_valid is 1 cycle.

Decomposition:
- Shared package modulator_pkg holds:
  - typedef enum state_t {IDLE, PRE, SYNC, LEN, PAY, DRAIN, GAP};
  - default constants for PREAMBLE_BYTE, SYNC_WORD, GAP_LEN;
  - localparam HDR_LEN = 3.
- No sub-module: one FSM plus counters plus the output register, in a single module.

Test Plan:
- Basic frame: reset, then start with N=2, payload 8'hA1, 8'hA2, i_ready_output=1 always. Expect o_data sequence 55 55 55 55 D3 91 02 A1 A2 on consecutive cycles; o_done high on the A2 transfer cycle; o_busy low exactly 16 cycles after that.
- Zero length: start with N=0. Expect 55×4 D3 91 00, then o_done; o_ready_payload never asserted.
- Backpressure: N=3 with i_ready_output toggled 1,0,0,1 and randomly. Expect an identical byte sequence, o_data stable while o_valid && !i_ready_output, no duplicates.
- Host starvation: N=3 with i_valid low for 5 cycles after the first payload byte. Expect o_valid low during the starve, the frame resumes, exactly 3 payload bytes consumed, and a 4th host byte left unaccepted.
- Start ignored: i_start pulsed mid-PAY and during GAP. Expect no effect; the next start after o_busy falls produces a new frame.
- Async reset mid-frame: assert i_reset=0 during SYNC, between clock edges. Expect all outputs 0 immediately; after release, a fresh start yields a full correct frame.
